// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t        - controller states (IDLE / RUN / DONE)
//   SS_DEFAULT_W   - default operand/result width
//   ss_cnt_width() - width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int SS_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit over clog2 so the counter can hold W itself; this also
  // keeps the counter at least one bit wide when W=1.
  function automatic int ss_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor used as the datapath slice of serial_subtractor.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit  a ^ b ^ bin
//   bout out borrow out      (~a & b) | (~(a ^ b) & bin)
// ---------------------------------------------------------------------------
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Computes {Bout, D} = A - B - Bin one bit per clock, LSB first, using a
// single full_subtractor slice. Operands are captured on an in_valid/in_ready
// handshake, the result is presented on an out_valid/out_ready handshake.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for operands, in_ready=1
//   RUN     | shifting W bits through the slice, one per cycle
//   DONE    | result held on D/Bout until out_ready
//
// Parameters:
//   W          operand/result width, 1..32
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A/B/Bin present
//   in_ready   block can accept operands (IDLE)
//   A, B, Bin  minuend, subtrahend, borrow-in
//   out_valid  D/Bout hold a finished result (DONE)
//   out_ready  consumer accepts the result
//   D          difference A-B-Bin mod 2^W
//   Bout       borrow-out, 1 when A < B+Bin
//   busy       high in RUN and DONE
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = SS_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] D,
  output logic         Bout,
  output logic         busy
);

  localparam int CW = ss_cnt_width(W);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_d;
  logic            r_br;
  logic            r_bout;

  logic            w_d;
  logic            w_bout;
  logic            w_last;

  // The slice always looks at bit 0 of the operand shift registers; the
  // running borrow lives in r_br between cycles.
  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bout;
          // New difference bit enters at the MSB; after W cycles the first
          // (LSB) bit has walked down to bit 0.
          r_d   <= (r_d >> 1) | (W'(w_d) << (W - 1));
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bout  <= w_bout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All handshake outputs decode the state register only, so nothing on the
  // input side reaches an output combinationally.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign D         = r_d;
  assign Bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int NG = 3;  // instances: W=8 (directed + random), W=1, W=32

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv[NG];
  logic        ordy[NG];
  logic        bin_s[NG];
  logic [31:0] a_s[NG];
  logic [31:0] b_s[NG];
  logic        ir[NG];
  logic        ov[NG];
  logic        bo[NG];
  logic        busy_s[NG];
  logic [31:0] d_s[NG];

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_log[$];
  bit          aux_go = 1'b0;
  bit          done_s[NG];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    int unsigned acc;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction, result reduced to w bits.
  function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic bin, input int unsigned acc);
    exp_t   e;
    longint m;
    longint diff;
    m      = (longint'(1) << w) - 1;
    diff   = (longint'(a) & m) - (longint'(b) & m) - longint'(bin);
    e.d    = 32'(diff & m);
    e.bout = (diff < 0);
    e.acc  = acc;
    return e;
  endfunction

  for (genvar g = 0; g < NG; g++) begin : gen_dut
    localparam int WG = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    logic [WG-1:0] w_d;
    exp_t q[$];
    logic prev_ov;

    serial_subtractor #(.W(WG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .A         (a_s[g][WG-1:0]),
      .B         (b_s[g][WG-1:0]),
      .Bin       (bin_s[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .D         (w_d),
      .Bout      (bo[g]),
      .busy      (busy_s[g])
    );
    assign d_s[g] = 32'(w_d);

    // Monitor / scoreboard: checks whatever the DUT presents, pushes the
    // expected result whenever an accept is about to happen.
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        prev_ov = 1'b0;
      end else begin
        check($sformatf("w%0d_busy", WG), busy_s[g], q.size() != 0);
        check($sformatf("w%0d_in_ready", WG), ir[g], q.size() == 0);
        if (ov[g]) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL w%0d_unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", WG, cyc);
          end else begin
            if (!prev_ov) check($sformatf("w%0d_latency", WG), cyc, q[0].acc + WG);
            check($sformatf("w%0d_D", WG), d_s[g], q[0].d);
            check($sformatf("w%0d_Bout", WG), bo[g], q[0].bout);
            if (ordy[g]) void'(q.pop_front());
          end
        end
        prev_ov = ov[g];
        if (iv[g] && ir[g]) begin
          q.push_back(ref_model(WG, a_s[g], b_s[g], bin_s[g], cyc + 1));
          if (g == 0) acc_log.push_back(cyc + 1);
        end
      end
    end

    if (g != 0) begin : gen_aux
      initial begin
        iv[g] = 1'b0; ordy[g] = 1'b1; a_s[g] = '0; b_s[g] = '0; bin_s[g] = 1'b0;
        wait (aux_go);
        rand_ops(g, 1000, 60000);
        done_s[g] = 1'b1;
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int g, input int n, input int budget);
    int ops = 0;
    int cycles = 0;
    while (ops < n && cycles < budget) begin
      @(posedge clk); #1;
      iv[g]    = ($urandom_range(0, 3) != 0);
      a_s[g]   = pick_operand();
      b_s[g]   = pick_operand();
      bin_s[g] = 1'($urandom_range(0, 1));
      ordy[g]  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv[g] && ir[g]) ops++;
      cycles++;
    end
    check($sformatf("rand_ops_completed_g%0d", g), ops, n);
    @(posedge clk); #1;
    iv[g] = 1'b0;
    ordy[g] = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy_s[g] && cycles < 100);
    check($sformatf("rand_drain_g%0d", g), busy_s[g], 1'b0);
  endtask

  // Present one operand set on instance 0 and hold it until accepted.
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n = 0;
    iv[0] = 1'b1; a_s[0] = {24'h0, a}; b_s[0] = {24'h0, b}; bin_s[0] = bin;
    do begin
      @(negedge clk);
      n++;
    end while (!ir[0] && n < 50);
    check("issue_accept_timeout", ir[0], 1'b1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    a_s[0] = $urandom; b_s[0] = $urandom; bin_s[0] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ov0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[0] && n < 100);
    check("out_valid_timeout", ov[0], 1'b1);
  endtask

  task automatic run_op0(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb);
    issue0(a, b, bin);
    wait_ov0();
    check({name, "_D"}, d_s[0], {24'h0, ed});
    check({name, "_Bout"}, bo[0], eb);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned rel_cyc;
    int n;
    iv[0] = 1'b0; ordy[0] = 1'b1; a_s[0] = '0; b_s[0] = '0; bin_s[0] = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", ir[0], 1'b1);
    check("reset_out_valid", ov[0], 1'b0);
    check("reset_busy", busy_s[0], 1'b0);
    check("reset_D", d_s[0], 32'h0);
    check("reset_Bout", bo[0], 1'b0);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
    run_op0("basic_5_minus_3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    if (acc_log.size() > 0) check("first_accept_edge", acc_log[0], rel_cyc + 1);
    else check("first_accept_logged", acc_log.size(), 1);

    run_op0("zero_minus_one", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op0("ff_minus_ff_bin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op0("no_borrow_equal", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    ordy[0] = 1'b0;
    issue0(8'h37, 8'h12, 1'b1);
    wait_ov0();
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", ov[0], 1'b1);
      check("bp_D", d_s[0], 32'h24);
      check("bp_Bout", bo[0], 1'b0);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", ov[0], 1'b0);
    check("bp_release_in_ready", ir[0], 1'b1);

    // Reset in the middle of RUN aborts the operation.
    issue0(8'h55, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov[0], 1'b0);
    check("abort_busy", busy_s[0], 1'b0);
    check("abort_in_ready", ir[0], 1'b1);
    check("abort_D", d_s[0], 32'h0);
    check("abort_Bout", bo[0], 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_result", ov[0], 1'b0);
    end
    @(posedge clk); #1;
    run_op0("after_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // Back-to-back: in_valid held high, operands scrambled every cycle.
    acc_log.delete();
    iv[0] = 1'b1; a_s[0] = 32'h40; b_s[0] = 32'h01; bin_s[0] = 1'b0; ordy[0] = 1'b1;
    n = 0;
    while (acc_log.size() < 3 && n < 80) begin
      @(posedge clk); #1;
      a_s[0] = $urandom; b_s[0] = $urandom; bin_s[0] = 1'($urandom_range(0, 1));
      n++;
    end
    iv[0] = 1'b0;
    check("b2b_accept_count", acc_log.size() >= 3, 1'b1);
    if (acc_log.size() >= 3) begin
      check("b2b_interval_1", acc_log[1] - acc_log[0], 10);
      check("b2b_interval_2", acc_log[2] - acc_log[1], 10);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_s[0] && n < 100);
    check("b2b_drain", busy_s[0], 1'b0);

    // Random phase on all three widths in parallel.
    aux_go = 1'b1;
    rand_ops(0, 1000, 40000);
    n = 0;
    while (!(done_s[1] && done_s[2]) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("aux_random_done", done_s[1] && done_s[2], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (legal range 1..32).
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set A/B/Bin present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  W  minuend.
REQ-007 B  input  W  subtrahend.
REQ-008 Bin  input  1  borrow-in.
REQ-009 out_valid  output  1  D/Bout hold a finished result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 D  output  W  difference A-B-Bin mod 2^W.
REQ-012 Bout  output  1  borrow-out, 1 when A < B+Bin (unsigned).
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; accept occurs when in_valid&in_ready at a rising edge, which registers A, B and Bin, clears the bit counter and moves to RUN.
REQ-016 RUN: in_ready=0; one bit per cycle, LSB first: d=a^b^br; br_next=(~a&b)|(~(a^b)&br); br initialised from Bin.
REQ-017 RUN: the bit counter increments each cycle; the difference bit shifts into the result register MSB-ward so D is bit-aligned after W cycles.
REQ-018 Once the RUN cycle with counter=W-1 completes, the FSM moves to DONE and out_valid=1 exactly W cycles after the accepting edge.
REQ-019 DONE: D and Bout stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 DONE with out_ready=1 at an edge: result consumed, FSM returns to IDLE; in_ready=1 the following cycle.
REQ-021 in_ready is 0 in DONE, so in_valid is not accepted in the same cycle as out_ready; minimum issue interval is W+2 cycles.
REQ-022 in_valid in RUN/DONE is ignored and A/B/Bin changes do not affect the operation in flight.
REQ-023 W=1 is legal: out_valid one cycle after the accepting edge.
REQ-024 All outputs are driven from registers or the state register, with no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 forces IDLE, in_ready=1, out_valid=0, busy=0, D=0, Bout=0, counter=0 and operand registers=0, immediately and independent of clk.
REQ-026 Reset during RUN or DONE aborts the operation; no result is produced after release.
REQ-027 First accept is possible at the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package holds the state enum (IDLE/RUN/DONE) and the default width constant.
REQ-029 The single sub-module is full_subtractor (a, b, bin -> d, bout), combinational, instantiated once, with bout per REQ-016.
REQ-030 The counter width is clog2(W)+1.

Verification
REQ-031 W=8, A=0x05, B=0x03, Bin=0 -> out_valid 8 cycles after accept; D=0x02, Bout=0.
REQ-032 A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1; A=0xFF, B=0xFF, Bin=1 -> D=0xFF, Bout=1.
REQ-033 Backpressure: out_ready low for 5 cycles after out_valid -> D/Bout/out_valid unchanged; out_ready=1 -> IDLE next cycle.
REQ-034 rst_n pulsed low at RUN cycle 4 -> outputs reset asynchronously; no out_valid after release; new op A=0x10, B=0x01 -> D=0x0F.
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> successive accepts W+2 cycles apart; changing A during RUN does not alter the result.
REQ-036 Random 1000 ops at W=1, 8 and 32 vs reference model {Bout,D} = A-B-Bin.
